// File: rtl/regfile_writeback_ctrl.sv
// regfile_writeback_ctrl: write-port driver for the 4x8 register file.
// Write-back results are queued in a small FIFO and issued one at a time on
// write_reg/write_data/signal_regwrite. Optional idle gap cycles after each
// write let the register file refresh its read outputs. hz_stall flags reads
// of registers that still have a queued or in-flight write.
// Optional feature macro: WB_FWD_EN (adds fwd_valid1/2, fwd_data1/2).
module regfile_writeback_ctrl #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [1:0] in_reg,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [1:0] write_reg,
  output logic [7:0] write_data,
  output logic       signal_regwrite,
  input  logic [1:0] chk_reg1,
  input  logic [1:0] chk_reg2,
  output logic       hz_stall,
`ifdef WB_FWD_EN
  output logic       fwd_valid1,
  output logic [7:0] fwd_data1,
  output logic       fwd_valid2,
  output logic [7:0] fwd_data2,
`endif
  output logic       idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP} state_t;

  state_t        state, state_nxt;
  logic [9:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    gap_cnt, gap_nxt;
  logic          full, push, pop;
  logic          match1, match2;
  logic [PW-1:0] idx;

  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;
  assign idle     = (count == '0) && (state == S_IDLE);
  assign hz_stall = match1 || match2;

  // Issue sequencing: pop the head when allowed, count out the idle gap.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (GAP_CYCLES > 0) begin
          state_nxt = S_GAP;
          gap_nxt   = 2'(GAP_CYCLES - 1);
        end else if (count != '0) begin
          pop = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt != '0) begin
          gap_nxt = gap_cnt - 2'd1;
        end else if (count != '0) begin
          pop       = 1'b1;
          state_nxt = S_WRITE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, FIFO pointers/count and registered write-port outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      gap_cnt         <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      write_reg       <= '0;
      write_data      <= '0;
      signal_regwrite <= 1'b0;
    end else begin
      state           <= state_nxt;
      gap_cnt         <= gap_nxt;
      signal_regwrite <= pop;
      if (pop) begin
        write_reg  <= mem[rd_ptr][9:8];
        write_data <= mem[rd_ptr][7:0];
        rd_ptr     <= rd_ptr + PW'(1);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; push is already gated off during reset via in_ready.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {in_reg, in_data};
  end

  // Hazard match over every valid FIFO entry plus the in-flight write.
  // Entries are scanned oldest to newest so a later match overrides an
  // earlier one, which gives the newest-wins forwarding priority.
  always_comb begin
    match1 = signal_regwrite && (write_reg == chk_reg1);
    match2 = signal_regwrite && (write_reg == chk_reg2);
    idx    = '0;
`ifdef WB_FWD_EN
    fwd_data1 = write_data;
    fwd_data2 = write_data;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if (mem[idx][9:8] == chk_reg1) begin
          match1 = 1'b1;
`ifdef WB_FWD_EN
          fwd_data1 = mem[idx][7:0];
`endif
        end
        if (mem[idx][9:8] == chk_reg2) begin
          match2 = 1'b1;
`ifdef WB_FWD_EN
          fwd_data2 = mem[idx][7:0];
`endif
        end
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid1 = match1;
  assign fwd_valid2 = match2;
`endif

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Testbench for regfile_writeback_ctrl: two instances (GAP_CYCLES=0 and 2)
// share the stimulus; each is checked every cycle against a queue-based
// reference built from the issue-spacing and ordering rules.
module tb_regfile_writeback_ctrl;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_reg = '0;
  logic [7:0] in_data = '0;
  logic [1:0] chk_reg1 = '0;
  logic [1:0] chk_reg2 = '0;

  logic       rdy  [2];
  logic [1:0] wreg [2];
  logic [7:0] wdat [2];
  logic       wen  [2];
  logic       hz   [2];
  logic       idl  [2];
`ifdef WB_FWD_EN
  logic       fv1 [2];
  logic [7:0] fd1 [2];
  logic       fv2 [2];
  logic [7:0] fd2 [2];
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  regfile_writeback_ctrl #(.DEPTH(DEPTH), .GAP_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_reg(in_reg),
    .in_data(in_data), .in_ready(rdy[0]), .write_reg(wreg[0]),
    .write_data(wdat[0]), .signal_regwrite(wen[0]), .chk_reg1(chk_reg1),
    .chk_reg2(chk_reg2), .hz_stall(hz[0]),
`ifdef WB_FWD_EN
    .fwd_valid1(fv1[0]), .fwd_data1(fd1[0]), .fwd_valid2(fv2[0]), .fwd_data2(fd2[0]),
`endif
    .idle(idl[0])
  );

  regfile_writeback_ctrl #(.DEPTH(DEPTH), .GAP_CYCLES(2)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_reg(in_reg),
    .in_data(in_data), .in_ready(rdy[1]), .write_reg(wreg[1]),
    .write_data(wdat[1]), .signal_regwrite(wen[1]), .chk_reg1(chk_reg1),
    .chk_reg2(chk_reg2), .hz_stall(hz[1]),
`ifdef WB_FWD_EN
    .fwd_valid1(fv1[1]), .fwd_data1(fd1[1]), .fwd_valid2(fv2[1]), .fwd_data2(fd2[1]),
`endif
    .idle(idl[1])
  );

  // Reference model: pending queue, last issued write, edge of last issue.
  logic [9:0] mq [2][$];
  bit         msig [2];
  logic [1:0] mreg [2];
  logic [7:0] mdata [2];
  int         mlast [2];
  int         gp [2];
  int         t;

  task automatic chk(input string tag, input int k, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  // Newest pending or in-flight write to register c.
  task automatic model_fwd(input int k, input logic [1:0] c,
                           output bit v, output logic [7:0] d);
    v = 1'b0;
    d = '0;
    if (msig[k] && mreg[k] == c) begin
      v = 1'b1;
      d = mdata[k];
    end
    foreach (mq[k][i]) begin
      if (mq[k][i][9:8] == c) begin
        v = 1'b1;
        d = mq[k][i][7:0];
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      msig[k]  = 1'b0;
      mreg[k]  = '0;
      mdata[k] = '0;
      mlast[k] = -100;
    end
  endtask

  // One cycle: drive inputs, check all outputs mid-cycle, advance the model.
  task automatic do_cycle(input bit v, input logic [1:0] r, input logic [7:0] d,
                          input bit rst, input logic [1:0] c1, input logic [1:0] c2);
    bit         ev1, ev2, acc;
    logic [7:0] ed1, ed2;
    logic [9:0] e;
    @(negedge clock);
    in_valid = v; in_reg = r; in_data = d; reset = rst;
    chk_reg1 = c1; chk_reg2 = c2;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_fwd(k, c1, ev1, ed1);
      model_fwd(k, c2, ev2, ed2);
      chk("in_ready", k, 8'(rdy[k]), 8'(!rst && mq[k].size() < DEPTH));
      chk("signal_regwrite", k, 8'(wen[k]), 8'(msig[k]));
      chk("write_reg", k, 8'(wreg[k]), 8'(mreg[k]));
      chk("write_data", k, wdat[k], mdata[k]);
      chk("idle", k, 8'(idl[k]), 8'(mq[k].size() == 0 && (t - mlast[k]) > gp[k]));
      chk("hz_stall", k, 8'(hz[k]), 8'(ev1 || ev2));
`ifdef WB_FWD_EN
      chk("fwd_valid1", k, 8'(fv1[k]), 8'(ev1));
      chk("fwd_valid2", k, 8'(fv2[k]), 8'(ev2));
      if (ev1) chk("fwd_data1", k, fd1[k], ed1);
      if (ev2) chk("fwd_data2", k, fd2[k], ed2);
`endif
    end
    @(posedge clock);
    t++;
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        acc = v && (mq[k].size() < DEPTH);
        if (mq[k].size() > 0 && (t - mlast[k]) >= 1 + gp[k]) begin
          e        = mq[k].pop_front();
          msig[k]  = 1'b1;
          mreg[k]  = e[9:8];
          mdata[k] = e[7:0];
          mlast[k] = t;
        end else begin
          msig[k] = 1'b0;
        end
        if (acc) mq[k].push_back({r, d});
      end
    end
  endtask

  task automatic idle_cycles(input int n, input logic [1:0] c1, input logic [1:0] c2);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 2'd0, 8'h00, 1'b0, c1, c2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tries;
    gp[0] = 0;
    gp[1] = 2;
    t = 0;
    model_reset();

    // Initial reset (outputs unknown before it), then a checked reset cycle.
    reset = 1'b1;
    repeat (2) @(posedge clock);
    do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd0);

    // Single write to reg2.
    do_cycle(1'b1, 2'd2, 8'h5A, 1'b0, 2'd2, 2'd3);
    idle_cycles(6, 2'd2, 2'd3);

    // Three back-to-back pushes.
    do_cycle(1'b1, 2'd0, 8'h11, 1'b0, 2'd0, 2'd3);
    do_cycle(1'b1, 2'd1, 8'h22, 1'b0, 2'd0, 2'd3);
    do_cycle(1'b1, 2'd3, 8'h33, 1'b0, 2'd0, 2'd3);
    idle_cycles(12, 2'd1, 2'd3);

    // Seven entries held until the gapped instance accepts each one.
    for (int n = 0; n < 7; n++) begin
      tries = 0;
      while (mq[1].size() >= DEPTH && tries < 20) begin
        do_cycle(1'b1, 2'(n), 8'h70 + 8'(n), 1'b0, 2'(n), 2'd3);
        tries++;
      end
      do_cycle(1'b1, 2'(n), 8'h70 + 8'(n), 1'b0, 2'(n), 2'd3);
    end
    idle_cycles(25, 2'd1, 2'd2);

    // Hazard on reg1 (chk_reg1=1) versus a non-matching check (chk_reg1=2).
    do_cycle(1'b1, 2'd1, 8'hC1, 1'b0, 2'd1, 2'd0);
    idle_cycles(6, 2'd1, 2'd0);
    do_cycle(1'b1, 2'd1, 8'hC2, 1'b0, 2'd2, 2'd0);
    idle_cycles(6, 2'd2, 2'd0);

    // Reset during the second of three writes.
    do_cycle(1'b1, 2'd0, 8'hA0, 1'b0, 2'd0, 2'd1);
    do_cycle(1'b1, 2'd1, 8'hA1, 1'b0, 2'd0, 2'd1);
    do_cycle(1'b1, 2'd2, 8'hA2, 1'b0, 2'd0, 2'd1);
    do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd1);
    idle_cycles(6, 2'd2, 2'd1);

    // Two writes to the same register: newest value forwarded.
    do_cycle(1'b1, 2'd2, 8'h10, 1'b0, 2'd2, 2'd0);
    do_cycle(1'b1, 2'd2, 8'h20, 1'b0, 2'd2, 2'd0);
    idle_cycles(10, 2'd2, 2'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      do_cycle(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
               8'($urandom), 1'($urandom_range(0, 59) == 0),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    idle_cycles(20, 2'd0, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
